// File: rtl/walking_one_rr_arbiter.sv
// Round-robin arbiter for one shared resource: registered walking-one grant,
// binary owner index, and a hold limit that forces release from a hogging owner.
module walking_one_rr_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int MAX_HOLD  = 16,
   parameter int CNT_WIDTH = 5,
   parameter int IDX_WIDTH = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [NUM_REQ-1:0]   i_done,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [IDX_WIDTH-1:0] o_owner,
   output logic                 o_busy,
   output logic                 o_timeout,
   output logic                 o_dbg_state
);

   // Handshake: a requester holds i_req high for as long as it wants the resource;
   // it owns the resource while its o_grant bit is high, and ends ownership either
   // by pulsing its i_done bit or by dropping i_req. Grant always returns to zero
   // for at least one cycle before the next owner (bus turnaround).

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t                 r_state, w_state_nxt;
   logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
   logic [IDX_WIDTH-1:0]   r_owner, w_owner_nxt;
   logic                   r_busy, w_busy_nxt;
   logic                   r_timeout, w_timeout_nxt;
   logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0]     r_ptr, w_ptr_nxt;

   logic                   w_found;
   logic [IDX_WIDTH-1:0]   w_pick_idx;
   logic [NUM_REQ-1:0]     w_pick_oh;
   logic                   w_done_own;
   logic                   w_req_own;
   logic                   w_force;
   logic                   w_release;

   // Circular scan starting at the pointer bit; first set request wins.
   always_comb begin
      int v_ptr_idx;
      int v_idx;
      v_ptr_idx  = 0;
      w_found    = 1'b0;
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_ptr[i]) v_ptr_idx = i;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = v_ptr_idx + k;
         if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
         if (!w_found && i_req[v_idx]) begin
            w_found    = 1'b1;
            w_pick_idx = IDX_WIDTH'(v_idx);
         end
      end
   end

   assign w_pick_oh  = NUM_REQ'(1) << w_pick_idx;
   assign w_done_own = |(i_done & r_grant);
   assign w_req_own  = |(i_req & r_grant);
   assign w_force    = (MAX_HOLD != 0) && (r_cnt == LP_LAST);
   assign w_release  = w_done_own || !w_req_own || w_force;

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_owner_nxt   = r_owner;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;
      w_cnt_nxt     = r_cnt;
      w_ptr_nxt     = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_OWNED;
               w_grant_nxt = w_pick_oh;
               w_owner_nxt = w_pick_idx;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = '0;
            end
         end
         ST_OWNED: begin
            if (w_release) begin
               w_state_nxt   = ST_IDLE;
               w_grant_nxt   = '0;
               w_owner_nxt   = '0;
               w_busy_nxt    = 1'b0;
               w_ptr_nxt     = {r_grant[NUM_REQ-2:0], r_grant[NUM_REQ-1]};
               // A normal release on the same edge as the limit wins: no timeout.
               w_timeout_nxt = w_force && !w_done_own && w_req_own;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_owner_nxt = '0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         r_ptr     <= NUM_REQ'(1);
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_owner   <= w_owner_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ptr     <= w_ptr_nxt;
      end
   end

   assign o_grant     = r_grant;
   assign o_owner     = r_owner;
   assign o_busy      = r_busy;
   assign o_timeout   = r_timeout;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_walking_one_rr_arbiter.sv
// Bench for walking_one_rr_arbiter: directed vector table, multi-cycle hold-limit
// sequences, and random traffic against an index-based reference model.
module tb_walking_one_rr_arbiter;

   localparam int N        = 3;
   localparam int MAX_HOLD = 16;
   localparam int LIMIT    = N * (MAX_HOLD + 1);
   localparam int W        = N + 2 + 3;

   logic         clk;
   logic         i_rst;
   logic [N-1:0] i_req;
   logic [N-1:0] i_done;
   logic [N-1:0] o_grant;
   logic [1:0]   o_owner;
   logic         o_busy;
   logic         o_timeout;
   logic         o_dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: owner index (-1 when free), pointer index, cycles held.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_held  = 0;
   logic m_to    = 1'b0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] done;
      logic [N-1:0] g;
      logic [1:0]   own;
      logic         busy;
      logic         to;
   } vec_t;

   vec_t vecs[$];

   walking_one_rr_arbiter #(
      .NUM_REQ(N), .MAX_HOLD(MAX_HOLD), .CNT_WIDTH(5), .IDX_WIDTH(2)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_done(i_done),
      .o_grant(o_grant), .o_owner(o_owner), .o_busy(o_busy),
      .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_pack();
      logic [N-1:0] g;
      logic [1:0]   own;
      logic         busy;
      g    = '0;
      own  = '0;
      busy = (m_owner >= 0);
      if (busy) begin
         g[m_owner] = 1'b1;
         own        = 2'(m_owner);
      end
      return {g, own, busy, m_to, busy};
   endfunction

   task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] done, input logic rst);
      int i;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (m_owner < 0 && req[i]) begin
               m_owner = i;
               m_held  = 1;
            end
         end
      end else begin
         m_to = 1'b0;
         if (done[m_owner] || !req[m_owner] || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
            m_to    = (MAX_HOLD != 0 && m_held == MAX_HOLD) && !done[m_owner] && req[m_owner];
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_held = m_held + 1;
         end
      end
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] done, input logic rst);
      i_req  = req;
      i_done = done;
      i_rst  = rst;
      model_step(req, done, rst);
      exp_q.push_back(model_pack());
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] dut_pack();
      return {o_grant, o_owner, o_busy, o_timeout, o_dbg_state};
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got grant/owner/busy/timeout/state=%b required=%b", name, got, exp);
      end
   endtask

   // Compare against a fixed expectation; the model entry is still consumed.
   task automatic check_fixed(input string name, input logic [N-1:0] g, input logic [1:0] own,
                              input logic busy, input logic to);
      logic [W-1:0] unused_m;
      unused_m = exp_q.pop_front();
      check(name, dut_pack(), {g, own, busy, to, busy});
   endtask

   task automatic check_model(input string name);
      check(name, dut_pack(), exp_q.pop_front());
   endtask

   task automatic add(input logic rst, input logic [N-1:0] req, input logic [N-1:0] done,
                      input logic [N-1:0] g, input logic [1:0] own, input logic busy, input logic to);
      vec_t v;
      v.rst = rst; v.req = req; v.done = done; v.g = g; v.own = own; v.busy = busy; v.to = to;
      vecs.push_back(v);
   endtask

   initial begin
      logic [N-1:0] req_r;
      logic [N-1:0] done_r;
      logic         rst_r;
      logic [N-1:0] prev_g;
      int           wait_c[N];
      int           worst;

      i_rst  = 1'b1;
      i_req  = '0;
      i_done = '0;

      // Round robin with Done on 3rd grant cycle
      add(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
      add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);
      add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);
      add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);
      add(0, 3'b111, 3'b001, 3'b000, 2'd0, 0, 0);
      add(0, 3'b111, 3'b000, 3'b010, 2'd1, 1, 0);
      add(0, 3'b111, 3'b000, 3'b010, 2'd1, 1, 0);
      add(0, 3'b111, 3'b000, 3'b010, 2'd1, 1, 0);
      add(0, 3'b111, 3'b010, 3'b000, 2'd0, 0, 0);
      add(0, 3'b111, 3'b000, 3'b100, 2'd2, 1, 0);
      add(0, 3'b111, 3'b000, 3'b100, 2'd2, 1, 0);
      add(0, 3'b111, 3'b000, 3'b100, 2'd2, 1, 0);
      add(0, 3'b111, 3'b100, 3'b000, 2'd0, 0, 0);
      add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);
      // Single requester 2, drop, pointer wraps to 0
      add(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
      add(0, 3'b100, 3'b000, 3'b100, 2'd2, 1, 0);
      add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
      add(0, 3'b111, 3'b000, 3'b001, 2'd0, 1, 0);
      add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
      // Non-owner Done ignored, reset mid-grant, pointer back to 0
      add(0, 3'b001, 3'b000, 3'b001, 2'd0, 1, 0);
      add(0, 3'b001, 3'b110, 3'b001, 2'd0, 1, 0);
      add(1, 3'b001, 3'b000, 3'b000, 2'd0, 0, 0);
      add(0, 3'b110, 3'b000, 3'b010, 2'd1, 1, 0);
      add(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0);
      // Done while idle is ignored
      add(0, 3'b000, 3'b111, 3'b000, 2'd0, 0, 0);

      for (int v = 0; v < vecs.size(); v++) begin
         drive(vecs[v].req, vecs[v].done, vecs[v].rst);
         check_fixed($sformatf("vec%0d", v), vecs[v].g, vecs[v].own, vecs[v].busy, vecs[v].to);
      end

      // Hold limit: 16 cycles of grant, timeout gap, then re-grant
      for (int k = 1; k <= MAX_HOLD; k++) begin
         drive(3'b010, 3'b000, 1'b0);
         check_fixed($sformatf("hold_c%0d", k), 3'b010, 2'd1, 1, 0);
      end
      drive(3'b010, 3'b000, 1'b0);
      check_fixed("timeout_pulse", 3'b000, 2'd0, 0, 1);
      drive(3'b010, 3'b000, 1'b0);
      check_fixed("regrant_after_timeout", 3'b010, 2'd1, 1, 0);

      // Done on the forced-release edge: release without timeout
      for (int k = 2; k <= MAX_HOLD; k++) begin
         drive(3'b010, 3'b000, 1'b0);
         check_fixed($sformatf("hold2_c%0d", k), 3'b010, 2'd1, 1, 0);
      end
      drive(3'b010, 3'b010, 1'b0);
      check_fixed("done_at_limit", 3'b000, 2'd0, 0, 0);
      drive(3'b000, 3'b000, 1'b0);
      check_fixed("idle_after_limit", 3'b000, 2'd0, 0, 0);

      // Random traffic against the model plus invariants
      req_r  = '0;
      prev_g = o_grant;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) req_r[i] = ~req_r[i];
         end
         done_r = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 7)) : '0;
         rst_r  = ($urandom_range(0, 999) == 0);
         drive(req_r, done_r, rst_r);
         check_model($sformatf("rand_c%0d", c));

         n_tests++;
         if ($countones(o_grant) > 1) begin
            n_fail++;
            $display("FAIL onehot_c%0d: got grant=%b required at most one bit", c, o_grant);
         end
         n_tests++;
         if (prev_g != '0 && o_grant != '0 && o_grant != prev_g) begin
            n_fail++;
            $display("FAIL gap_c%0d: got grant %b -> %b required a zero cycle between", c, prev_g, o_grant);
         end
         worst = 0;
         for (int i = 0; i < N; i++) begin
            if (rst_r || !req_r[i] || o_grant[i]) wait_c[i] = 0;
            else wait_c[i] = wait_c[i] + 1;
            if (wait_c[i] > worst) worst = wait_c[i];
         end
         n_tests++;
         if (worst > LIMIT) begin
            n_fail++;
            $display("FAIL starve_c%0d: got wait=%0d required <= %0d", c, worst, LIMIT);
            for (int i = 0; i < N; i++) wait_c[i] = 0;
         end
         prev_g = o_grant;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
